// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/REQ/HOLD handshake with instruction memory,
// PC sequencing with branch/jump. Optional InstrCount port via FETCH_INSTR_COUNT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemData,
  input  logic        Stall,
  input  logic [1:0]  Branch,
  input  logic        Zero,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [5:0]  OPCode,
  output logic [5:0]  FCode,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4
`ifdef FETCH_INSTR_COUNT_EN
  ,
  output logic [31:0] InstrCount
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state;
  logic [31:0] br_off;
  logic [31:0] jmp_tgt;
  logic [31:0] next_pc;
  logic        taken;

  assign ImemAddr = PC;
  assign PCPlus4  = PC + 32'd4;
  assign OPCode   = Instr[31:26];
  assign FCode    = Instr[5:0];

  always_comb begin
    br_off  = {{14{Instr[15]}}, Instr[15:0], 2'b00};
    jmp_tgt = {PCPlus4[31:28], Instr[25:0], 2'b00};
    taken   = ((Branch == 2'b00) && Zero) || ((Branch == 2'b01) && !Zero);
    next_pc = PCPlus4;
    if (taken)
      next_pc = PCPlus4 + br_off;
    else if (Branch == 2'b10)
      next_pc = jmp_tgt;
  end

  // ImemReq/InstrValid are registered alongside the state so they never glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      PC         <= RESET_PC;
      Instr      <= '0;
      ImemReq    <= 1'b0;
      InstrValid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state   <= REQ;
          ImemReq <= 1'b1;
        end
        REQ: begin
          if (ImemAck) begin
            state      <= HOLD;
            Instr      <= ImemData;
            ImemReq    <= 1'b0;
            InstrValid <= 1'b1;
          end
        end
        HOLD: begin
          if (!Stall) begin
            state      <= REQ;
            PC         <= next_pc;
            ImemReq    <= 1'b1;
            InstrValid <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          ImemReq    <= 1'b0;
          InstrValid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_INSTR_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      InstrCount <= '0;
    else if (state == HOLD && !Stall)
      InstrCount <= InstrCount + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by randomized
// fetches checked against a transaction-level PC/instruction model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck = 1'b0;
  logic [31:0] ImemData = '0;
  logic        Stall = 1'b0;
  logic [1:0]  Branch = 2'b11;
  logic        Zero = 1'b0;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [5:0]  OPCode;
  logic [5:0]  FCode;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
`ifdef FETCH_INSTR_COUNT_EN
  logic [31:0] InstrCount;
`endif

  int unsigned nchecks = 0;
  int unsigned npass   = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_instr;
  logic [31:0] exp_count;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .reset     (reset),
    .ImemReq   (ImemReq),
    .ImemAddr  (ImemAddr),
    .ImemAck   (ImemAck),
    .ImemData  (ImemData),
    .Stall     (Stall),
    .Branch    (Branch),
    .Zero      (Zero),
    .InstrValid(InstrValid),
    .Instr     (Instr),
    .OPCode    (OPCode),
    .FCode     (FCode),
    .PC        (PC),
    .PCPlus4   (PCPlus4)
`ifdef FETCH_INSTR_COUNT_EN
    ,
    .InstrCount(InstrCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got === exp)
      npass++;
    else
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Next fetch address from the branch rules, in plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] instr,
                                             input logic [1:0] br, input logic z);
    logic [31:0] seq;
    int          off;
    seq = pc + 32'd4;
    if ((br == 2'b00 && z) || (br == 2'b01 && !z)) begin
      off = int'($signed(instr[15:0]));
      return seq + 32'(off * 4);
    end
    if (br == 2'b10)
      return (seq & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
    return seq;
  endfunction

  task automatic check_common();
    check("instr",   Instr,                exp_instr);
    check("pc",      PC,                   exp_pc);
    check("pcplus4", PCPlus4,              exp_pc + 32'd4);
    check("opcode",  32'(OPCode),          32'(exp_instr[31:26]));
    check("fcode",   32'(FCode),           32'(exp_instr[5:0]));
`ifdef FETCH_INSTR_COUNT_EN
    check("count",   InstrCount,           exp_count);
`endif
  endtask

  task automatic check_req();
    check("req_imemreq", 32'(ImemReq),    32'd1);
    check("req_addr",    ImemAddr,        exp_pc);
    check("req_valid",   32'(InstrValid), 32'd0);
    check_common();
  endtask

  task automatic check_hold();
    check("hold_imemreq", 32'(ImemReq),    32'd0);
    check("hold_valid",   32'(InstrValid), 32'd1);
    check_common();
  endtask

  // One instruction: dly wait cycles before ack, then stalls cycles held in HOLD.
  task automatic fetch(input int unsigned dly, input logic [31:0] word,
                       input int unsigned stalls, input logic [1:0] br, input logic z);
    for (int unsigned i = 0; i <= dly; i++) begin
      @(negedge clk);
      check_req();
      ImemAck  = (i == dly);
      ImemData = (i == dly) ? word : $urandom;
      Stall    = 1'($urandom_range(0, 1));
      Branch   = 2'($urandom_range(0, 3));
      Zero     = 1'($urandom_range(0, 1));
    end
    exp_instr = word;
    for (int unsigned i = 0; i <= stalls; i++) begin
      @(negedge clk);
      check_hold();
      ImemAck  = 1'($urandom_range(0, 1));
      ImemData = $urandom;
      if (i < stalls) begin
        Stall  = 1'b1;
        Branch = 2'($urandom_range(0, 3));
        Zero   = 1'($urandom_range(0, 1));
      end else begin
        Stall  = 1'b0;
        Branch = br;
        Zero   = z;
      end
    end
    exp_pc    = model_next(exp_pc, word, br, z);
    exp_count = exp_count + 32'd1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_imemreq"}, 32'(ImemReq),    32'd0);
    check({tag, "_valid"},   32'(InstrValid), 32'd0);
    check({tag, "_instr"},   Instr,           32'd0);
    check({tag, "_pc"},      PC,              RST_PC);
    check({tag, "_pcplus4"}, PCPlus4,         RST_PC + 32'd4);
    check({tag, "_opcode"},  32'(OPCode),     32'd0);
    check({tag, "_fcode"},   32'(FCode),      32'd0);
`ifdef FETCH_INSTR_COUNT_EN
    check({tag, "_count"},   InstrCount,      32'd0);
`endif
  endtask

  // Reset asserted between edges must act at once; acks during reset and IDLE are ignored.
  task automatic apply_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    ImemAck  = 1'b1;
    ImemData = $urandom;
    #1 check_reset_vals("rst_async");
    repeat (2) @(posedge clk);
    #1 check_reset_vals("rst_held");
    @(negedge clk);
    reset     = 1'b0;
    ImemData  = $urandom | 32'h1;
    exp_pc    = RST_PC;
    exp_instr = '0;
    exp_count = '0;
    #1 check("idle_imemreq", 32'(ImemReq), 32'd0);
  endtask

  // Reset in the middle of a request, with the memory acking one cycle later.
  task automatic reset_in_req();
    @(negedge clk);
    check_req();
    ImemAck = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_vals("rst_req");
    @(negedge clk);
    ImemAck  = 1'b1;
    ImemData = 32'hDEAD_BEEF;
    @(negedge clk);
    check_reset_vals("rst_lateack");
    reset     = 1'b0;
    ImemAck   = 1'b0;
    exp_pc    = RST_PC;
    exp_instr = '0;
    exp_count = '0;
    #1 check("rel_imemreq", 32'(ImemReq), 32'd0);
  endtask

  initial begin
    apply_reset();
    // Sequential fetches of an add: addresses 0x0, 0x4, 0x8, 0xC.
    repeat (4) fetch(0, 32'h0000_0020, 0, 2'b11, 1'b0);
    // BEQ at 0x10 with offset -1: taken loops to 0x10, not taken falls through to 0x14.
    fetch(0, 32'h1000_FFFF, 0, 2'b00, 1'b1);
    fetch(0, 32'h1000_FFFF, 0, 2'b00, 1'b0);
    // Jump to 0x40, then jump from 0x40 to 0x400.
    fetch(0, 32'h0800_0010, 0, 2'b10, 1'b0);
    fetch(0, 32'h0800_0100, 0, 2'b10, 1'b0);
    // Slow memory plus a long stall: InstrValid held 5 cycles.
    fetch(3, 32'h0123_4567, 4, 2'b01, 1'b1);
    // Back to 0, branch -2 words to 0xFFFF_FFFC, then sequential wrap to 0.
    fetch(1, 32'h0800_0000, 0, 2'b10, 1'b1);
    fetch(0, 32'h1000_FFFE, 0, 2'b00, 1'b1);
    fetch(0, 32'h0000_0020, 1, 2'b11, 1'b1);
    fetch(0, 32'h1400_0003, 0, 2'b01, 1'b1);
    reset_in_req();
    repeat (5) fetch(0, 32'h0000_0020, 0, 2'b11, 1'b0);
    apply_reset();
    for (int k = 0; k < 40; k++)
      fetch($urandom_range(0, 3), $urandom,
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    @(negedge clk);
    check_req();
    $display("%0d/%0d checks passed", npass, nchecks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ImemReq  output  1  instruction-memory read request.
REQ-005 ImemAddr  output  32  read address; equals PC.
REQ-006 ImemAck  input  1  memory accepted the request; ImemData is valid on the same edge.
REQ-007 ImemData  input  32  instruction word.
REQ-008 Stall  input  1  downstream hold; the issued instruction is not consumed.
REQ-009 Branch  input  2  controller branch code: 00 BEQ, 01 BNE, 10 JUMP, 11 none.
REQ-010 Zero  input  1  ALU zero flag for the issued instruction.
REQ-011 InstrValid  output  1  Instr and its fields are valid.
REQ-012 Instr  output  32  instruction register.
REQ-013 OPCode  output  6  Instr[31:26], to the controller.
REQ-014 FCode  output  6  Instr[5:0], to the controller.
REQ-015 PC  output  32  address of the issued instruction.
REQ-016 PCPlus4  output  32  PC+4, mod 2^32.

Function
REQ-017 The FSM SHALL have three states.
- IDLE -> REQ unconditionally.
- REQ -> HOLD on the rising edge where ImemAck=1.
- HOLD -> REQ on the rising edge where Stall=0.
REQ-018 In REQ, ImemReq SHALL be 1 and ImemAddr SHALL equal PC, both stable until ImemAck; in IDLE and HOLD, ImemReq SHALL be 0.
REQ-019 On the ImemAck edge in REQ, Instr SHALL load ImemData; ImemAck in any other state SHALL be ignored.
REQ-020 InstrValid SHALL be 1 exactly in HOLD; Instr, PC and PCPlus4 SHALL be stable throughout HOLD.
REQ-021 The PC SHALL update only on the HOLD edge with Stall=0, to a next-PC value chosen as follows.
- Taken branch (Branch=00 with Zero=1, or Branch=01 with Zero=0): PCPlus4 + (sign-extend(Instr[15:0]) << 2).
- Branch=10: {PCPlus4[31:28], Instr[25:0], 2'b00}.
- Otherwise: PCPlus4.
REQ-022 All PC arithmetic SHALL be 32-bit, wrap modulo 2^32, and keep PC[1:0]=00.
REQ-023 Stall=1 in HOLD SHALL hold all state; Branch and Zero SHALL be sampled only on the releasing edge.
REQ-024 Minimum throughput SHALL be one instruction per two cycles (ImemAck in the REQ cycle, Stall=0).

Reset
REQ-025 While reset=1, the block SHALL hold these values, regardless of clk:
- state IDLE, PC=RESET_PC, Instr=0;
- ImemReq=0, InstrValid=0, OPCode=0, FCode=0, PCPlus4=RESET_PC+4.
REQ-026 Reset asserted mid-REQ or mid-HOLD SHALL abandon the access; a late ImemAck SHALL be ignored.
REQ-027 The first ImemReq after reset release SHALL assert in the second cycle, with ImemAddr=RESET_PC.

Configuration
REQ-028 Macro FETCH_INSTR_COUNT_EN defined: add output InstrCount (32), reset to 0, incremented on every HOLD edge with Stall=0, wrapping from 32'hFFFF_FFFF to 0.
REQ-029 Macro FETCH_INSTR_COUNT_EN undefined: port InstrCount and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 Reset release, zero-wait memory returns 32'h0000_0020 (add), Stall=0, Branch=11 -> ImemAddr sequence 0x0, 0x4, 0x8, with InstrValid high every other cycle.
REQ-031 PC=0x10, Instr=32'h1000_FFFF, Branch=00, Zero=1 -> next ImemAddr=0x10; with Zero=0 -> next ImemAddr=0x14.
REQ-032 PC=0x40, Instr=32'h0800_0100, Branch=10 -> next ImemAddr=0x0000_0400.
REQ-033 ImemAck delayed 3 cycles, then Stall=1 for 4 cycles -> ImemAddr held, Instr/PC unchanged, InstrValid=1 for exactly 5 cycles.
REQ-034 PC=0xFFFF_FFFC, Branch=11 -> next ImemAddr=0x0000_0000; reset asserted in REQ with ImemAck 1 cycle later -> ImemReq=0 immediately and Instr stays 0.
REQ-035 With FETCH_INSTR_COUNT_EN defined, 5 instructions issued, reset, 2 more issued -> InstrCount reads 5, then 0, then 2.
